// File: rtl/rx_phase_ctrl_pkg.sv
// Shared definitions for the upstream receive-phase sequencer: status codes
// reported to the host and the FSM state encoding.
package rx_phase_ctrl_pkg;

    localparam logic [1:0] ST_DONE  = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;
    localparam logic [1:0] ST_LIMIT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CLOSE = 2'd2
    } state_e;

endpackage

// File: rtl/rx_phase_ctrl.sv
// Opens/closes the upstream receive window, counts data beats, and ends the
// phase on transport done, host abort, beat limit or idle timeout.
module rx_phase_ctrl #(
    parameter int CNT_W = 32,
    parameter int TMO_W = 32,
    parameter int PH_W  = 16
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_areset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [TMO_W-1:0] i_timeout_cycles,
    input  logic [CNT_W-1:0] i_max_beats,
    output logic             o_rx_rcving,
    input  logic             i_axis_hsked,
    input  logic             i_axis_tlast,
    input  logic             i_rx_done,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_beat_count,
    output logic [PH_W-1:0]  o_phase_count
);
    import rx_phase_ctrl_pkg::*;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [1:0]         status_q, status_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               recv_q, recv_d;
    logic               done_q, done_d;

    logic               data_beat;
    logic [CNT_W-1:0]   beat_inc;
    logic [TMO_W-1:0]   timer_inc;

    // The tlast marker beat is a framing word, not payload, so it never counts.
    assign data_beat = i_axis_hsked & ~i_axis_tlast;
    assign beat_inc  = (beat_q == '1)  ? beat_q  : beat_q  + CNT_W'(1);
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        lim_d    = lim_q;
        timer_d  = timer_q;
        beat_d   = beat_q;
        status_d = status_q;
        phase_d  = phase_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    tmo_d    = i_timeout_cycles;
                    lim_d    = i_max_beats;
                    timer_d  = '0;
                    beat_d   = '0;
                    status_d = ST_DONE;
                    state_d  = S_RECV;
                end
            end
            S_RECV: begin
                beat_d  = data_beat ? beat_inc : beat_q;
                timer_d = data_beat ? '0 : timer_inc;
                if (i_abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_CLOSE;
                end else if (i_rx_done) begin
                    status_d = ST_DONE;
                    state_d  = S_CLOSE;
                end else if (lim_q != '0 && data_beat && beat_inc == lim_q) begin
                    status_d = ST_LIMIT;
                    state_d  = S_CLOSE;
                end else if (tmo_q != '0 && !data_beat && timer_inc == tmo_q) begin
                    status_d = ST_TMO;
                    state_d  = S_CLOSE;
                end
                if (state_d == S_CLOSE) begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_CLOSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered copies of the next state so they line up with it.
    assign recv_d = (state_d == S_RECV);
    assign done_d = (state_d == S_CLOSE);

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            lim_q    <= '0;
            timer_q  <= '0;
            beat_q   <= '0;
            status_q <= '0;
            phase_q  <= '0;
            recv_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            lim_q    <= lim_d;
            timer_q  <= timer_d;
            beat_q   <= beat_d;
            status_q <= status_d;
            phase_q  <= phase_d;
            recv_q   <= recv_d;
            done_q   <= done_d;
        end
    end

    assign o_rx_rcving   = recv_q;
    assign o_busy        = recv_q;
    assign o_done        = done_q;
    assign o_status      = status_q;
    assign o_beat_count  = beat_q;
    assign o_phase_count = phase_q;

endmodule

// File: doc/rx_phase_ctrl.md
# rx_phase_ctrl

Sequencer for the upstream (PAICore → AXI-Stream) receive phase. It opens and closes the receive window of the upstream transport by driving its `i_rx_rcving` input. While the window is open it counts handshaked data beats and watches for the transport's done pulse. It ends the phase on an idle timeout, a beat limit or a host abort, and reports completion status to the host register block.

## Interface
Parameters:
- `CNT_W`, 32: width of beat counter and beat limit
- `TMO_W`, 32: width of idle-timeout counter and threshold
- `PH_W`, 16: width of completed-phase counter

Ports:
- `s_axis_aclk`  in  1  clock
- `s_axis_areset`  in  1  reset; one clock; reset is asynchronous and active-high
- `i_start`  in  1  single-cycle pulse; opens a receive phase
- `i_abort`  in  1  single-cycle pulse; closes the phase immediately
- `i_timeout_cycles`  in  TMO_W  idle-cycle threshold; 0 disables the timeout
- `i_max_beats`  in  CNT_W  data-beat limit; 0 means unlimited
- `o_rx_rcving`  out  1  receive window; drives the transport's `i_rx_rcving`
- `i_axis_hsked`  in  1  transport `m_axis_hsked`
- `i_axis_tlast`  in  1  transport `m_axis_tlast`
- `i_rx_done`  in  1  transport `o_rx_done` pulse
- `o_busy`  out  1  high while a phase is open
- `o_done`  out  1  single-cycle pulse when a phase closes
- `o_status`  out  2  result code: 00 done, 01 timeout, 10 abort, 11 beat limit
- `o_beat_count`  out  CNT_W  data beats of the current or last phase
- `o_phase_count`  out  PH_W  number of closed phases; wraps modulo 2^PH_W

## Operation
- FSM states: IDLE, RECV, CLOSE.
- Reset values: state IDLE, all outputs 0, internal timer 0.
- **IDLE**
  - `o_rx_rcving` = 0.
  - On `i_start` with `i_abort` low:
    - latch `i_timeout_cycles` and `i_max_beats`; later changes do not affect the open phase
    - clear `o_beat_count`, timer and `o_status`
    - go to RECV.
  - `i_abort` in IDLE is ignored. When `i_start` and `i_abort` are both high, the FSM stays in IDLE.
- **RECV**
  - `o_rx_rcving` = 1 and `o_busy` = 1.
  - A data beat is `i_axis_hsked & ~i_axis_tlast`.
    - Each data beat increments `o_beat_count`, saturating at all-ones, and clears the timer.
    - Otherwise the timer increments, saturating.
    - The tlast (0xFFFF_FFFF_FFFF_FFFF marker) beat is never counted.
  - Exit conditions, evaluated on the same cycle, in priority order:
    1. `i_abort` → status 10
    2. `i_rx_done` → status 00
    3. latched limit ≠ 0 and the incremented count equals the limit → status 11
    4. latched timeout ≠ 0 and the incremented timer equals the timeout → status 01
  - Any exit goes to CLOSE. A beat that occurs on the exit cycle is still counted.
  - `i_start` in RECV is ignored.
- **CLOSE**
  - Lasts one cycle: `o_rx_rcving` = 0, `o_done` = 1, `o_phase_count` += 1.
  - Then go to IDLE.
  - `o_status` and `o_beat_count` hold until the next accepted `i_start`.
- Asserting `s_axis_areset` mid-phase returns the FSM to IDLE immediately and drops `o_rx_rcving` asynchronously. No `o_done` pulse is generated.

## Timing
- All outputs are registered.
- Start:
  - `i_start` sampled at edge N → `o_rx_rcving` and `o_busy` high from N+1.
  - The first countable beat is at edge N+1 or later.
- Close:
  - Exit condition at edge M → `o_rx_rcving` low and `o_done` high during M+1 → IDLE at M+2.
  - The earliest accepted restart is a `i_start` sampled at M+2.
- Timeout: with no beats, threshold T, and the phase opened at edge N, the timeout exit condition is true at edge N+T and `o_done` is high during N+T+1.
- Beat limit L: the exit fires on the cycle of the L-th data beat. `o_beat_count` = L during CLOSE.
- `o_status` updates on the same edge that `o_done` rises.

## Structure
- Shared package:
  - status code constants: `ST_DONE` = 2'b00, `ST_TMO` = 2'b01, `ST_ABORT` = 2'b10, `ST_LIMIT` = 2'b11
  - FSM state encoding
- Single module; no sub-module. A saturating counter is written inline twice.

## Test plan
- Start, 5 data beats, then `i_rx_done` (tlast beat handshaked in the same cycle) → status 00, `o_beat_count` = 5, one `o_done` pulse, `o_phase_count` = 1.
- Timeout = 10, no beats → `o_done` exactly 11 cycles after `i_start` sampling; status 01; `o_beat_count` = 0.
- Max beats = 3, beats on every cycle → CLOSE after the 3rd beat; status 11; `o_rx_rcving` low the following cycle.
- `i_abort` and `i_rx_done` on the same cycle in RECV → status 10. Separately, `i_start` and `i_abort` together in IDLE → stays IDLE with `o_busy` = 0.
- Timeout = 4, with a beat every 3 cycles for 20 cycles, then silence → no timeout during the activity; timeout fires 4 cycles after the last beat.
- Assert reset mid-RECV → `o_rx_rcving` = 0 immediately, all outputs 0, no `o_done`. A following `i_start` opens a normal phase.
